// File: rtl/mcoi_reset_filter_bank_if.sv
// Bus bundle for mcoi_reset_filter_bank: filter enable, async level inputs,
// glitch-flag clear and the filtered outputs. The design side uses the slave modport.
interface mcoi_reset_filter_bank_if #(
  parameter int unsigned N_CH = 1
);
  logic            cen_ie;
  logic [N_CH-1:0] data_i;
  logic            clr_i;
  logic [N_CH-1:0] data_o;
  logic [N_CH-1:0] glitch_o;

  modport master (
    output cen_ie, data_i, clr_i,
    input  data_o, glitch_o
  );

  modport slave (
    input  cen_ie, data_i, clr_i,
    output data_o, glitch_o
  );
endinterface

// File: rtl/mcoi_reset_filter_bank.sv
// Multi-channel level synchroniser, consecutive-cycle filter and assertion stretcher.
// Optional glitch detection is compiled in by defining MCOI_RESET_FILTER_GLITCH_EN.
module mcoi_reset_filter_bank #(
  parameter int unsigned     N_CH        = 1,
  parameter int unsigned     SYNC_STAGES = 2,
  parameter int unsigned     FILTER_LEN  = 8,
  parameter int unsigned     STRETCH_LEN = 0,
  parameter logic [N_CH-1:0] INV_MASK    = '0,
  parameter logic [N_CH-1:0] RST_VAL     = '1
) (
  input  logic                     clk_ik,
  input  logic                     rst_ir,
  mcoi_reset_filter_bank_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q [N_CH];
  logic [CNT_W-1:0]       cnt_q  [N_CH];
  logic [CNT_W-1:0]       cnt_d  [N_CH];
  logic [N_CH-1:0]        data_q;
  logic [N_CH-1:0]        data_d;
  logic [N_CH-1:0]        x;
  logic [N_CH-1:0]        blocked;

  always_comb begin
    x = '0;
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      x[ch] = sync_q[ch][SYNC_STAGES-1] ^ INV_MASK[ch];
    end
  end

  // Preloading with RST_VAL^INV_MASK makes x equal data_o at release, so no spurious edge.
  always_ff @(posedge clk_ik) begin
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      if (rst_ir) begin
        sync_q[ch] <= {SYNC_STAGES{RST_VAL[ch] ^ INV_MASK[ch]}};
      end else begin
        sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], bus.data_i[ch]};
      end
    end
  end

  always_comb begin
    data_d = data_q;
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      cnt_d[ch] = cnt_q[ch];
      if (bus.cen_ie) begin
        if (x[ch] == data_q[ch]) begin
          cnt_d[ch] = '0;
        end else if (!blocked[ch]) begin
          if (cnt_q[ch] == CNT_W'(FILTER_LEN - 1)) begin
            data_d[ch] = x[ch];
            cnt_d[ch]  = '0;
          end else begin
            cnt_d[ch] = cnt_q[ch] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_ik) begin
    if (rst_ir) begin
      data_q <= RST_VAL;
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        cnt_q[ch] <= '0;
      end
    end else begin
      data_q <= data_d;
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

  if (STRETCH_LEN > 0) begin : g_stretch
    localparam int unsigned HOLD_W = $clog2(STRETCH_LEN + 1);

    logic [HOLD_W-1:0] hold_q [N_CH];
    logic [HOLD_W-1:0] hold_d [N_CH];

    // Only a falling qualification is held off while the stretch is running.
    always_comb begin
      blocked = '0;
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        blocked[ch] = data_q[ch] & ~x[ch] & (hold_q[ch] != '0);
      end
    end

    always_comb begin
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        hold_d[ch] = hold_q[ch];
        if (bus.cen_ie) begin
          if (!data_q[ch] && data_d[ch]) begin
            hold_d[ch] = HOLD_W'(STRETCH_LEN);
          end else if (hold_q[ch] != '0) begin
            hold_d[ch] = hold_q[ch] - 1'b1;
          end
        end
      end
    end

    always_ff @(posedge clk_ik) begin
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        if (rst_ir) begin
          hold_q[ch] <= '0;
        end else begin
          hold_q[ch] <= hold_d[ch];
        end
      end
    end
  end else begin : g_no_stretch
    assign blocked = '0;
  end

  assign bus.data_o = data_q;

`ifdef MCOI_RESET_FILTER_GLITCH_EN
  logic [N_CH-1:0] glitch_q;
  logic [N_CH-1:0] glitch_d;
  logic [N_CH-1:0] glitch_set;

  // A partial count abandoned because x fell back to data_o marks a glitch.
  always_comb begin
    glitch_set = '0;
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      glitch_set[ch] = bus.cen_ie & (x[ch] == data_q[ch]) & (cnt_q[ch] != '0);
    end
    glitch_d = (glitch_q & ~{N_CH{bus.clr_i}}) | glitch_set;
  end

  always_ff @(posedge clk_ik) begin
    if (rst_ir) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign bus.glitch_o = glitch_q;
`else
  logic unused_clr;
  assign unused_clr   = bus.clr_i;
  assign bus.glitch_o = '0;
`endif

endmodule
